pipelined_dual_port_ram: RTL and testbench
==========================================

PIPELINED_DUAL_PORT_RAM -- requirements
Module: pipelined_dual_port_ram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of words.
REQ-003 The block SHALL have parameter ADDRESS_WIDTH, default `CLOG2(DEPTH), meaning address bus width.
REQ-004 The block SHALL have parameter SLICE_WIDTH, default 8, meaning bits per write-enable slice; WIDTH SHALL be a multiple of SLICE_WIDTH.
REQ-005 The block SHALL have parameter READ_LATENCY, default 1, legal range 1..4, meaning clock edges from read request to read_valid.
REQ-006 The block SHALL have parameter WRITE_THROUGH, default 1, meaning 1 = new data on same-address collision, 0 = old data.
REQ-007 The block SHALL have port clock, input, 1, meaning the single clock; all logic on rising edge.
REQ-008 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-009 The block SHALL have port write_enable, input, 1, meaning write request this cycle.
REQ-010 The block SHALL have port write_address, input, ADDRESS_WIDTH, meaning write word address.
REQ-011 The block SHALL have port write_slices, input, WIDTH/SLICE_WIDTH, meaning per-slice write mask, bit i covers data bits [i*SLICE_WIDTH +: SLICE_WIDTH].
REQ-012 The block SHALL have port write_data, input, WIDTH, meaning write data.
REQ-013 The block SHALL have port read_enable, input, 1, meaning read request this cycle.
REQ-014 The block SHALL have port read_address, input, ADDRESS_WIDTH, meaning read word address.
REQ-015 The block SHALL have port read_data, output, WIDTH, meaning registered read data.
REQ-016 The block SHALL have port read_valid, output, 1, meaning read_data carries a response this cycle.

Function
REQ-017 On a rising edge with write_enable=1 and write_address<DEPTH, the block SHALL update only the slices whose write_slices bit is 1; other slices keep their value.
REQ-018 A write with write_address>=DEPTH or write_slices all zero SHALL leave memory unchanged.
REQ-019 A read_enable sampled at edge N SHALL produce read_valid=1 for exactly one cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY edges after the request cycle.
REQ-020 Reads SHALL be fully pipelined: read_enable may be asserted every cycle, and responses SHALL return in request order, one per request, with no stalls or drops.
REQ-021 Memory SHALL be sampled at the request edge; writes at later edges SHALL NOT alter a response already in flight.
REQ-022 On same-edge read and write to the same in-range address with WRITE_THROUGH=1, the response SHALL merge the written slices from write_data with unwritten slices from memory.
REQ-023 On the same collision with WRITE_THROUGH=0, the response SHALL be the memory word before the write.
REQ-024 A read with read_address>=DEPTH SHALL return zero with read_valid asserted normally.
REQ-025 read_data SHALL hold its last response value while read_valid=0.
REQ-026 Illegal parameter values (READ_LATENCY outside 1..4, WIDTH not a multiple of SLICE_WIDTH) SHALL cause an elaboration error.

Reset
REQ-027 While reset=1, all memory words, all pipeline stage data and valid bits, read_data and read_valid SHALL be 0, independent of clock.
REQ-028 Reads in flight when reset asserts SHALL be discarded; no read_valid pulse SHALL follow reset release for them.
REQ-029 Requests presented on the first rising edge after reset deasserts SHALL be accepted normally.

Verification
REQ-030 Reset then read addresses 0..DEPTH-1 -> all read_data 0, one read_valid per request.
REQ-031 READ_LATENCY=3: write 0xDEADBEEF to address 5; next cycle read 5 -> read_valid high exactly 3 edges after request, read_data 0xDEADBEEF.
REQ-032 Word 2 = 0x11223344; write 0xAABBCCDD with write_slices=4'b0101 -> read 2 returns 0x11BB33DD.
REQ-033 Word 7 = 0x00000001; same-edge write 0x000000FF all slices and read 7 -> WRITE_THROUGH=1 returns 0x000000FF, WRITE_THROUGH=0 returns 0x00000001.
REQ-034 READ_LATENCY=4: back-to-back reads of addresses 1,2,3 then reset at cycle 2 of flight -> no read_valid after release; memory reads back 0.
REQ-035 DEPTH=12: write to address 13 then read 13 and read 0 -> read 13 returns 0 with read_valid; address 0 unchanged.

Source files
------------

// File: rtl/pipelined_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_dual_port_ram
// Brief    : One write port with slice mask, one pipelined read port with
//            configurable latency, collision policy and asynchronous clear.
// Revision : 1.0
// ============================================================================
module pipelined_dual_port_ram #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int SLICE_WIDTH   = 8,
  parameter int READ_LATENCY  = 1,
  parameter bit WRITE_THROUGH = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [ADDRESS_WIDTH-1:0]       write_address,
  input  logic [WIDTH/SLICE_WIDTH-1:0]   write_slices,
  input  logic [WIDTH-1:0]               write_data,
  input  logic                           read_enable,
  input  logic [ADDRESS_WIDTH-1:0]       read_address,
  output logic [WIDTH-1:0]               read_data,
  output logic                           read_valid
);

  localparam int SLICES = WIDTH / SLICE_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = DEPTH[ADDRESS_WIDTH:0];

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_read_latency
    $fatal(1, "pipelined_dual_port_ram: READ_LATENCY must be within 1..4");
  end

  if ((WIDTH % SLICE_WIDTH) != 0) begin : g_bad_slice_width
    $fatal(1, "pipelined_dual_port_ram: WIDTH must be a multiple of SLICE_WIDTH");
  end

  logic [WIDTH-1:0]        mem [DEPTH];
  logic                    write_in_range;
  logic                    read_in_range;
  logic                    collision;
  logic [WIDTH-1:0]        read_word;
  logic [WIDTH-1:0]        stage_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] stage_valid;

  assign write_in_range = write_enable && ({1'b0, write_address} < DEPTH_LIMIT);
  assign read_in_range  = {1'b0, read_address} < DEPTH_LIMIT;
  assign collision      = write_in_range && read_in_range && (write_address == read_address);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_in_range) begin
      for (int s = 0; s < SLICES; s++) begin
        if (write_slices[s]) begin
          mem[write_address][s*SLICE_WIDTH +: SLICE_WIDTH] <= write_data[s*SLICE_WIDTH +: SLICE_WIDTH];
        end
      end
    end
  end

  // Word captured at the request edge; on a write-through collision the
  // freshly written slices override the stored ones.
  always_comb begin
    read_word = '0;
    if (read_in_range) begin
      read_word = mem[read_address];
      if (WRITE_THROUGH && collision) begin
        for (int s = 0; s < SLICES; s++) begin
          if (write_slices[s]) begin
            read_word[s*SLICE_WIDTH +: SLICE_WIDTH] = write_data[s*SLICE_WIDTH +: SLICE_WIDTH];
          end
        end
      end
    end
  end

  // Data stages only load alongside a valid, so the last stage holds the
  // most recent response while no new one arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_data[i] <= '0;
      end
    end else begin
      stage_valid[0] <= read_enable;
      if (read_enable) begin
        stage_data[0] <= read_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        if (stage_valid[i-1]) begin
          stage_data[i] <= stage_data[i-1];
        end
      end
    end
  end

  assign read_data  = stage_data[READ_LATENCY-1];
  assign read_valid = stage_valid[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_dual_port_ram
// Brief    : Directed bench driving three RAM configurations in lockstep.
// Revision : 1.0
// ============================================================================
module tb_pipelined_dual_port_ram;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic [3:0]  write_address = '0;
  logic [3:0]  write_slices = '0;
  logic [31:0] write_data = '0;
  logic        read_enable = 1'b0;
  logic [3:0]  read_address = '0;

  logic [31:0] rdata [3];
  logic        rvalid [3];
  int          lat [3];

  int checks = 0;
  int errors = 0;

  logic [3:0]  burst_addr [16];
  logic [31:0] burst_exp [16];

  always #5 clock = ~clock;

  // d0: defaults (latency 1, write-through); d1: latency 3, write-through;
  // d2: depth 12, latency 4, read-old-data.
  pipelined_dual_port_ram u_rl1 (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_slices(write_slices),
    .write_data(write_data), .read_enable(read_enable),
    .read_address(read_address), .read_data(rdata[0]), .read_valid(rvalid[0])
  );

  pipelined_dual_port_ram #(.READ_LATENCY(3), .WRITE_THROUGH(1'b1)) u_rl3 (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_slices(write_slices),
    .write_data(write_data), .read_enable(read_enable),
    .read_address(read_address), .read_data(rdata[1]), .read_valid(rvalid[1])
  );

  pipelined_dual_port_ram #(.DEPTH(12), .READ_LATENCY(4), .WRITE_THROUGH(1'b0)) u_rl4 (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .write_address(write_address), .write_slices(write_slices),
    .write_data(write_data), .read_enable(read_enable),
    .read_address(read_address), .read_data(rdata[2]), .read_valid(rvalid[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; leaves at a negedge with write_enable low.
  task automatic write_word(input logic [3:0] addr, input logic [3:0] sl, input logic [31:0] data);
    write_enable  = 1'b1;
    write_address = addr;
    write_slices  = sl;
    write_data    = data;
    @(negedge clock);
    write_enable  = 1'b0;
  endtask

  // Single read; checks each instance's valid pulse position and that the
  // returned word is held afterwards. Optionally writes the same address on
  // the edge following the request.
  task automatic read_check(input string tag, input logic [3:0] addr,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                            input bit wr_after = 1'b0, input logic [31:0] wdat = 32'h0);
    logic [31:0] ex [3];
    ex[0] = e0;
    ex[1] = e1;
    ex[2] = e2;
    read_enable  = 1'b1;
    read_address = addr;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) begin
        read_enable  = 1'b0;
        write_enable = wr_after;
        if (wr_after) begin
          write_address = addr;
          write_slices  = 4'hF;
          write_data    = wdat;
        end
      end
      if (k == 2) write_enable = 1'b0;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("%s valid d%0d k%0d", tag, d, k), 32'(rvalid[d]), 32'(k == lat[d]));
        if (k >= lat[d]) check($sformatf("%s data d%0d k%0d", tag, d, k), rdata[d], ex[d]);
      end
    end
  endtask

  // Back-to-back reads from burst_addr; responses checked in order against burst_exp.
  task automatic burst(input string tag, input int n);
    int idx [3];
    for (int d = 0; d < 3; d++) idx[d] = 0;
    for (int c = 0; c < n + 7; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (rvalid[d]) begin
          if (idx[d] < n) check($sformatf("%s data d%0d #%0d", tag, d, idx[d]), rdata[d], burst_exp[idx[d]]);
          idx[d]++;
        end
      end
      if (c < n) begin
        read_enable  = 1'b1;
        read_address = burst_addr[c];
      end else begin
        read_enable = 1'b0;
      end
      @(negedge clock);
    end
    for (int d = 0; d < 3; d++) check($sformatf("%s count d%0d", tag, d), idx[d], n);
  endtask

  initial begin
    lat[0] = 1;
    lat[1] = 3;
    lat[2] = 4;

    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset data d%0d", d), rdata[d], 32'h0);
      check($sformatf("reset valid d%0d", d), 32'(rvalid[d]), 32'h0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      burst_addr[i] = 4'(i);
      burst_exp[i]  = 32'h0;
    end
    burst("zero_sweep", 16);

    write_word(4'd5, 4'hF, 32'hDEADBEEF);
    read_check("rd5", 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

    write_word(4'd2, 4'hF, 32'h11223344);
    write_word(4'd2, 4'b0101, 32'hAABBCCDD);
    read_check("slices", 4'd2, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    write_word(4'd7, 4'hF, 32'h00000001);
    write_enable = 1'b1; write_address = 4'd7; write_slices = 4'hF; write_data = 32'h000000FF;
    read_check("collide7", 4'd7, 32'h000000FF, 32'h000000FF, 32'h00000001);
    read_check("after7", 4'd7, 32'h000000FF, 32'h000000FF, 32'h000000FF);

    write_enable = 1'b1; write_address = 4'd2; write_slices = 4'b0010; write_data = 32'h99999999;
    read_check("merge2", 4'd2, 32'h11BB99DD, 32'h11BB99DD, 32'h11BB33DD);

    read_check("inflight", 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h12345678);
    read_check("rd5_new", 4'd5, 32'h12345678, 32'h12345678, 32'h12345678);

    write_word(4'd5, 4'h0, 32'hFFFFFFFF);
    read_check("nomask", 4'd5, 32'h12345678, 32'h12345678, 32'h12345678);

    write_word(4'd13, 4'hF, 32'hCAFEF00D);
    read_check("rd13", 4'd13, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);
    read_check("rd0", 4'd0, 32'h0, 32'h0, 32'h0);

    write_word(4'd1, 4'hF, 32'hA1A1A1A1);
    write_word(4'd3, 4'hF, 32'hC3C3C3C3);
    burst_addr[0] = 4'd1; burst_exp[0] = 32'hA1A1A1A1;
    burst_addr[1] = 4'd2; burst_exp[1] = 32'h11BB99DD;
    burst_addr[2] = 4'd3; burst_exp[2] = 32'hC3C3C3C3;
    burst("order", 3);

    // Reset lands while reads of 1 and 2 are still in the deeper pipelines.
    read_enable = 1'b1; read_address = 4'd1;
    @(negedge clock);
    read_address = 4'd2;
    @(negedge clock);
    read_enable = 1'b0;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("midreset data d%0d", d), rdata[d], 32'h0);
      check($sformatf("midreset valid d%0d", d), 32'(rvalid[d]), 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    write_enable = 1'b1; write_address = 4'd4; write_slices = 4'hF; write_data = 32'h0BADCAFE;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      write_enable = 1'b0;
      for (int d = 0; d < 3; d++) check($sformatf("flushed valid d%0d c%0d", d, c), 32'(rvalid[d]), 32'h0);
    end
    read_check("post_rst4", 4'd4, 32'h0BADCAFE, 32'h0BADCAFE, 32'h0BADCAFE);
    read_check("post_rst1", 4'd1, 32'h0, 32'h0, 32'h0);
    read_check("post_rst3", 4'd3, 32'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
